// File: rtl/limit_monitor_pkg.sv
// limit_monitor_pkg: shared FSM state encoding and sample classification
package limit_monitor_pkg;
  typedef enum logic [1:0] {NORMAL = 2'd0, CLIPPING = 2'd1, FAULT = 2'd2} state_t;
  typedef enum logic [1:0] {IN_RANGE = 2'd0, CLIP_HI = 2'd1, CLIP_LO = 2'd2} cls_t;
endpackage

// File: rtl/limit_monitor_sat_counter.sv
// sat_counter: up counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  // clear beats increment; increment stops once the counter is full
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/limit_monitor.sv
// limit_monitor: clamps signed samples to +/-LIMIT and tracks sustained clipping into a sticky fault
module limit_monitor
  import limit_monitor_pkg::*;
#(
  parameter int BITS        = 11,
  parameter int LIMIT       = 1000,
  parameter int TRIP_CNT    = 16,
  parameter int RELEASE_CNT = 64,
  parameter int CNT_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [BITS-1:0] IN,
  input  logic                   clear,
  output logic                   out_valid,
  output logic signed [BITS-1:0] OUT,
  output logic                   clip_hi,
  output logic                   clip_lo,
  output logic [1:0]             state,
  output logic                   fault,
  output logic [CNT_BITS-1:0]    clip_count
);
  localparam int RUN_W   = $clog2(TRIP_CNT + 1);
  localparam int QUIET_W = $clog2(RELEASE_CNT + 1);
  localparam logic signed [BITS-1:0] LIM  = BITS'(LIMIT);
  localparam logic signed [BITS-1:0] NLIM = -LIM;

  if (LIMIT <= 0 || LIMIT > 2**(BITS-1) - 1 || TRIP_CNT < 1 || RELEASE_CNT < 1) begin : g_bad_param
    $error("limit_monitor: LIMIT, TRIP_CNT or RELEASE_CNT out of range");
  end

  state_t state_d, state_q;
  cls_t cls;
  logic clip, trip, rel;
  logic run_inc, run_clr, quiet_inc, quiet_clr, cnt_inc, cnt_clr;
  logic [RUN_W-1:0] run_q;
  logic [QUIET_W-1:0] quiet_q;
  logic out_valid_d, out_valid_q, clip_hi_d, clip_hi_q, clip_lo_d, clip_lo_q;
  logic signed [BITS-1:0] out_d, out_q;

  sat_counter #(.W(RUN_W)) u_run (.clk(clk), .rst(rst), .inc(run_inc), .clr(run_clr), .cnt(run_q));
  sat_counter #(.W(QUIET_W)) u_quiet (.clk(clk), .rst(rst), .inc(quiet_inc), .clr(quiet_clr), .cnt(quiet_q));
  sat_counter #(.W(CNT_BITS)) u_clips (.clk(clk), .rst(rst), .inc(cnt_inc), .clr(cnt_clr), .cnt(clip_count));

  // signed classification; exactly +/-LIMIT counts as in range
  always_comb begin
    cls  = (IN > LIM) ? CLIP_HI : (IN < NLIM) ? CLIP_LO : IN_RANGE;
    clip = cls != IN_RANGE;
    trip = (32'(run_q) + 32'd1) == TRIP_CNT;
    rel  = (32'(quiet_q) + 32'd1) == RELEASE_CNT;
  end

  // next state and counter control; clear overrides any sample arriving with it
  always_comb begin
    state_d   = state_q;
    run_inc   = 1'b0;
    run_clr   = 1'b0;
    quiet_inc = 1'b0;
    quiet_clr = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    if (clear) begin
      state_d   = (state_q == FAULT) ? NORMAL : state_q;
      run_clr   = 1'b1;
      quiet_clr = 1'b1;
      cnt_clr   = 1'b1;
    end else if (in_valid) begin
      cnt_inc = clip;
      if (state_q != FAULT) begin
        if (clip) begin
          run_inc   = 1'b1;
          quiet_clr = 1'b1;
          state_d   = trip ? FAULT : CLIPPING;
        end else begin
          run_clr = 1'b1;
          if (state_q == CLIPPING) begin
            quiet_inc = !rel;
            quiet_clr = rel;
            state_d   = rel ? NORMAL : CLIPPING;
          end
        end
      end
    end
  end

  // output datapath; a sample that finds or enters FAULT is forced to zero
  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    clip_hi_d   = clip_hi_q;
    clip_lo_d   = clip_lo_q;
    if (in_valid) begin
      out_d     = (state_d == FAULT) ? '0 : (cls == CLIP_HI) ? LIM : (cls == CLIP_LO) ? NLIM : IN;
      clip_hi_d = cls == CLIP_HI;
      clip_lo_d = cls == CLIP_LO;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NORMAL;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      clip_hi_q   <= 1'b0;
      clip_lo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      clip_hi_q   <= clip_hi_d;
      clip_lo_q   <= clip_lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign clip_hi   = clip_hi_q;
  assign clip_lo   = clip_lo_q;
  assign state     = state_q;
  assign fault     = state_q == FAULT;
endmodule

// File: tb/tb_limit_monitor.sv
// tb_limit_monitor: directed scoreboard bench for limit_monitor
module tb_limit_monitor;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear = 1'b0;
  logic signed [10:0] in_s = '0;
  logic out_valid, clip_hi, clip_lo, fault;
  logic signed [10:0] OUT;
  logic [1:0] state;
  logic [15:0] clip_count;

  logic s_valid = 1'b0, s_out_valid, s_hi, s_lo, s_fault;
  logic signed [10:0] s_in = '0, s_out;
  logic [1:0] s_state;
  logic [3:0] s_count;

  int errors = 0, checks = 0;
  bit mon_en = 1'b0;
  logic iv_d = 1'b0;

  typedef struct {int o; bit h; bit l; int s; int c;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  limit_monitor u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .IN(in_s), .clear(clear),
    .out_valid(out_valid), .OUT(OUT), .clip_hi(clip_hi), .clip_lo(clip_lo),
    .state(state), .fault(fault), .clip_count(clip_count)
  );

  limit_monitor #(.TRIP_CNT(32), .CNT_BITS(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .IN(s_in), .clear(1'b0),
    .out_valid(s_out_valid), .OUT(s_out), .clip_hi(s_hi), .clip_lo(s_lo),
    .state(s_state), .fault(s_fault), .clip_count(s_count)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input bit clr, input int eo, input bit eh, input bit el, input int es, input int ec);
    in_valid = 1'b1;
    in_s = 11'(x);
    clear = clr;
    q.push_back('{eo, eh, el, es, ec});
    tick();
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_OUT"}, 32'(OUT), 0);
    chk({tag, "_clip_hi"}, 32'(clip_hi), 0);
    chk({tag, "_clip_lo"}, 32'(clip_lo), 0);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_clip_count"}, 32'(clip_count), 0);
  endtask

  always @(posedge clk) iv_d <= rst ? 1'b0 : in_valid;

  // monitor: out_valid must trail in_valid by one cycle; each valid output is scored against the queue
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid_latency", 32'(out_valid), 32'(iv_d));
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: OUT=%0d with no expected sample", OUT);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("OUT", 32'(OUT), e.o);
          chk("clip_hi", 32'(clip_hi), 32'(e.h));
          chk("clip_lo", 32'(clip_lo), 32'(e.l));
          chk("state", 32'(state), e.s);
          chk("fault", 32'(fault), (e.s == 2) ? 1 : 0);
          chk("clip_count", 32'(clip_count), e.c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    // in-range, including both boundaries
    send(999, 0, 999, 0, 0, 0, 0);
    send(1000, 0, 1000, 0, 0, 0, 0);
    send(-1000, 0, -1000, 0, 0, 0, 0);
    // clamp both directions
    send(1001, 0, 1000, 1, 0, 1, 1);
    send(-1024, 0, -1000, 0, 1, 1, 2);
    tick();
    // clear outside FAULT keeps CLIPPING but zeroes the count
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_keeps_clipping", 32'(state), 1);
    chk("clear_zeroes_count", 32'(clip_count), 0);
    // trip: 16 clips separated by idle cycles
    for (int i = 1; i <= 16; i++) begin
      send(1023, 0, (i < 16) ? 1000 : 0, 1, 0, (i < 16) ? 1 : 2, i);
      tick();
    end
    // FAULT forces zero; clear with a sample releases it and passes that sample
    send(500, 0, 0, 0, 0, 2, 16);
    send(500, 1, 500, 0, 0, 0, 0);
    // release after 64 in-range samples
    send(1010, 0, 1000, 1, 0, 1, 1);
    send(-1010, 0, -1000, 0, 1, 1, 2);
    send(1010, 0, 1000, 1, 0, 1, 3);
    for (int i = 1; i <= 64; i++) send(100, 0, 100, 0, 0, (i == 64) ? 0 : 1, 3);
    // a clip at sample 40 restarts the quiet count
    send(1010, 0, 1000, 1, 0, 1, 4);
    send(1010, 0, 1000, 1, 0, 1, 5);
    send(1010, 0, 1000, 1, 0, 1, 6);
    for (int k = 1; k <= 104; k++) begin
      if (k == 40) send(1010, 0, 1000, 1, 0, 1, 7);
      else send(100, 0, 100, 0, 0, (k == 104) ? 0 : 1, (k < 40) ? 6 : 7);
    end
    // reset mid-CLIPPING overrides a concurrent sample
    send(1010, 0, 1000, 1, 0, 1, 8);
    rst = 1'b1;
    in_valid = 1'b1;
    in_s = 11'sd1023;
    tick();
    chk_reset("mid_reset");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    // alternating hi/lo clips accumulate toward the trip
    for (int i = 1; i <= 16; i++)
      send((i % 2) ? 1023 : -1024, 0, (i == 16) ? 0 : ((i % 2) ? 1000 : -1000), (i % 2) == 1, (i % 2) == 0, (i == 16) ? 2 : 1, i);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("idle_clear_state", 32'(state), 0);
    chk("idle_clear_fault", 32'(fault), 0);
    chk("idle_clear_count", 32'(clip_count), 0);
    // narrow counter saturates without wrapping
    for (int i = 1; i <= 20; i++) begin
      s_valid = 1'b1;
      s_in = 11'sd1023;
      tick();
      if (i == 15) chk("sat_count_15", 32'(s_count), 15);
    end
    s_valid = 1'b0;
    chk("sat_count_20", 32'(s_count), 15);
    chk("sat_state", 32'(s_state), 1);
    tick();
    tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/limit_monitor.md
Name: limit_monitor

Overview:
- Supervisory clamp stage for signed sample streams: clamps each valid sample to ±LIMIT and classifies it (in range / clipped high / clipped low).
- Tracks sustained clipping with a three-state FSM: NORMAL, CLIPPING, FAULT.
- Latches a sticky fault that forces the output to zero until software clears it.
- Sits between a control-loop output and the actuator/DAC path; gives the loop observability of saturation events.

Parameters:
- BITS, 11, sample width (signed two's complement)
- LIMIT, 1000, clamp magnitude; must satisfy 0 < LIMIT <= 2^(BITS-1)-1 (elaboration-time check)
- TRIP_CNT, 16, consecutive clipped valid samples that trip FAULT (>= 1)
- RELEASE_CNT, 64, consecutive in-range valid samples to return CLIPPING -> NORMAL (>= 1)
- CNT_BITS, 16, width of the total clip event counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IN carries a sample this cycle
- IN  in  BITS  signed input sample
- clear  in  1  single-cycle fault clear request
- out_valid  out  1  OUT/clip flags valid (in_valid delayed 1 cycle)
- OUT  out  BITS  signed clamped sample (0 while in FAULT)
- clip_hi  out  1  sample aligned with OUT was > LIMIT
- clip_lo  out  1  sample aligned with OUT was < -LIMIT
- state  out  2  0=NORMAL, 1=CLIPPING, 2=FAULT (3 unused; decodes to NORMAL)
- fault  out  1  high whenever state==FAULT
- clip_count  out  CNT_BITS  total clipped valid samples since reset/clear; saturates at all-ones

Behaviour:
- Reset (rst=1 at clock edge): OUT=0, out_valid=0, clip_hi=0, clip_lo=0, state=NORMAL, fault=0, clip_count=0, internal run/quiet counters=0. Reset overrides clear and in_valid.
- Classification: hi = IN > LIMIT; lo = IN < -LIMIT; compare signed. IN == ±LIMIT is in range, not clipped.
- Latency: 1 cycle. out_valid(t+1) = in_valid(t).
  - On in_valid: OUT <= LIMIT if hi, -LIMIT if lo, else IN.
  - clip_hi/clip_lo <= hi/lo.
  - Exception: OUT <= 0 if the FSM is in FAULT or enters FAULT on this sample.
- in_valid=0: OUT, clip_hi, clip_lo, FSM and all counters hold. out_valid drops to 0.
- clip_count: +1 on every valid clipped sample, including in FAULT; saturates, never wraps.
- Internal counters: run (consecutive clipped) and quiet (consecutive in-range), each wide enough for TRIP_CNT and RELEASE_CNT respectively.
- NORMAL:
  - Valid clipped sample -> CLIPPING, run=1, quiet=0.
  - If TRIP_CNT==1, go directly to FAULT instead.
- CLIPPING:
  - Valid clipped sample: run+1, quiet=0; when run+1 == TRIP_CNT -> FAULT.
  - Valid in-range sample: run=0, quiet+1; when quiet+1 == RELEASE_CNT -> NORMAL, quiet=0.
- FAULT:
  - Sticky; samples still update clip_count and clip flags, but OUT=0.
  - clear=1 -> NORMAL, run=0, quiet=0, clip_count=0, effective next cycle.
- clear outside FAULT: resets clip_count, run and quiet only; state unchanged (CLIPPING stays CLIPPING).
- clear together with a valid sample:
  - clear wins for FSM and counters; that sample does not advance the FSM or clip_count.
  - OUT for that sample is the clamped value (FSM is no longer in FAULT).
- Trip cycle: the TRIP_CNT-th clipped sample already produces OUT=0 and fault=1 in the same output cycle.
- Hi and lo clips both count as clipping; alternating hi/lo samples accumulate run.

Decomposition:
- Shared package (e.g. ctrl_pkg): state encoding constants NORMAL/CLIPPING/FAULT as a 2-bit typedef; classification enum {IN_RANGE, CLIP_HI, CLIP_LO}.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturate at max). Used for clip_count and for the run/quiet counters.
- Clamp compare and the FSM stay in limit_monitor.

Test Plan:
- Reset/in-range: rst 2 cycles, then valid IN=999, 1000, -1000 -> one cycle later OUT=999, 1000, -1000; clip flags 0; state NORMAL; clip_count 0.
- Clamp/latency: valid IN=1001, then -1024 -> OUT=1000 with clip_hi=1, then OUT=-1000 with clip_lo=1; out_valid matches in_valid delayed 1; clip_count=2; state CLIPPING.
- Trip: 16 consecutive valid IN=1023 with idle (in_valid=0) gaps between them -> samples 1..15 give OUT=1000; sample 16 gives OUT=0, fault=1, state FAULT; gaps cause no state change.
- Release: enter CLIPPING with 3 clips, then 63 in-range samples (state CLIPPING), then a 64th -> NORMAL. Repeat with one clip at sample 40 -> quiet restarts, still CLIPPING after 64 total.
- Fault clear: in FAULT, IN=500 -> OUT=0. Pulse clear together with valid IN=500 -> OUT=500, state NORMAL, clip_count=0. Reset asserted mid-CLIPPING -> all outputs at reset values next cycle.
- Saturation: CNT_BITS=4, 20 clipped samples with TRIP_CNT=32 -> clip_count stops at 15, no wrap.
